// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and the FSM state type for the systolic MAC
// processing element.
//   DATA_W    operand / accumulator width (signed two's complement)
//   FRAC_BITS fractional bits of the Q2.13 format
//   PROD_W    full product width
//   MUL_CYC   multiplier step count, one step per multiplier bit
//   CNT_W     width of the multiplier step down-counter
package pe_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 13;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int MUL_CYC   = DATA_W;
  localparam int CNT_W     = $clog2(MUL_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } pe_state_t;

endpackage

// File: rtl/pe_seq_mul.sv
// pe_seq_mul: radix-2 signed shift-add multiplier, MUL_CYC steps per product.
//   clk     in  clock, rising edge
//   rst     in  asynchronous reset, active-high
//   start   in  load operands (a, b) and begin a new product
//   a       in  signed multiplicand
//   b       in  signed multiplier
//   done    out one-cycle pulse once product holds the final result
//   product out signed PROD_W-bit product, exact
module pe_seq_mul
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
        mplier  <= b;
        cnt     <= CNT_W'(MUL_CYC - 1);
        busy    <= 1'b1;
        product <= '0;
      end else if (busy) begin
        // The multiplier's top bit carries weight -2^(DATA_W-1), so the final
        // step (terminal count) subtracts the shifted multiplicand instead of adding.
        if (mplier[0]) begin
          if (cnt == '0) product <= product - mcand;
          else           product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pe_mac_unit.sv
// pe_mac_unit: systolic-array PE. Multiplies activation X by weight W (Q2.13),
// truncates the product back to 16 bits and accumulates it onto O_D, while
// forwarding the captured operands to the right and lower neighbours.
//   I_CLK   in  clock, rising edge
//   I_RST_N in  asynchronous reset, active-high
//   I_VLD   in  operand pair valid (sampled only in IDLE)
//   I_X     in  signed activation from the left
//   I_W     in  signed weight from above
//   O_VLD   out one-cycle pulse, O_D holds the new accumulated sum
//   O_X     out captured X, to the right
//   O_W     out captured W, downwards
//   O_D     out accumulated sum, downwards
//
// state | meaning
// IDLE  | waiting for I_VLD; accepts a pair and starts the multiplier
// BUSY  | multiplier stepping; inputs ignored
// DONE  | O_D just updated, O_VLD high for this cycle only
module pe_mac_unit
  import pe_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD,
  input  logic [DATA_W-1:0] I_X,
  input  logic [DATA_W-1:0] I_W,
  output logic              O_VLD,
  output logic [DATA_W-1:0] O_X,
  output logic [DATA_W-1:0] O_W,
  output logic [DATA_W-1:0] O_D
);

  pe_state_t         state;
  logic              mul_start;
  logic              mul_done;
  logic [PROD_W-1:0] product;
  logic [DATA_W-1:0] q;
  logic              unused_prod_bits;

  assign mul_start = (state == IDLE) && I_VLD;

  pe_seq_mul u_mul (
    .clk     (I_CLK),
    .rst     (I_RST_N),
    .start   (mul_start),
    .a       (I_X),
    .b       (I_W),
    .done    (mul_done),
    .product (product)
  );

  // Keep the sign, drop the integer bits that no longer fit (no saturation)
  // and the fraction bits below the LSB (floor toward -inf).
  assign q = {product[PROD_W-1], product[FRAC_BITS+DATA_W-2:FRAC_BITS]};
  assign unused_prod_bits = ^{product[PROD_W-2:FRAC_BITS+DATA_W-1],
                              product[FRAC_BITS-1:0]};

  always_ff @(posedge I_CLK or posedge I_RST_N) begin
    if (I_RST_N) begin
      state <= IDLE;
      O_VLD <= 1'b0;
      O_X   <= '0;
      O_W   <= '0;
      O_D   <= '0;
    end else begin
      case (state)
        IDLE: begin
          O_VLD <= 1'b0;
          if (I_VLD) begin
            O_X   <= I_X;
            O_W   <= I_W;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mul_done) begin
            O_D   <= O_D + q;
            O_VLD <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          O_VLD <= 1'b0;
          state <= IDLE;
        end
        default: begin
          O_VLD <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_unit.sv
// tb_pe_mac_unit: scoreboard bench for pe_mac_unit. The stimulus process
// pushes the expected accumulated sum (from a Q2.13 arithmetic model) at each
// accept; a negedge monitor pops and compares at every O_VLD pulse and also
// checks pulse width, accept-to-pulse latency and back-to-back spacing.
module tb_pe_mac_unit;

  localparam int MUL_CYC = 16;
  localparam int PULSE_LAT = MUL_CYC + 2;  // negedge count from accept to pulse
  localparam int PULSE_GAP = MUL_CYC + 3;

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  logic        I_CLK;
  logic        I_RST_N;
  logic        I_VLD;
  logic [15:0] I_X;
  logic [15:0] I_W;
  logic        O_VLD;
  logic [15:0] O_X;
  logic [15:0] O_W;
  logic [15:0] O_D;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pulses   = 0;
  int   last_pulse = 0;
  bit   have_last  = 0;
  bit   prev_vld   = 0;
  bit   b2b        = 0;
  exp_t sb[$];
  logic [15:0] acc = 16'h0000;

  pe_mac_unit dut (
    .I_CLK   (I_CLK),
    .I_RST_N (I_RST_N),
    .I_VLD   (I_VLD),
    .I_X     (I_X),
    .I_W     (I_W),
    .O_VLD   (O_VLD),
    .O_X     (O_X),
    .O_W     (O_W),
    .O_D     (O_D)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Q2.13 product truncated to 16 bits: floor(x*w / 2^13), integer bits
  // beyond the sign discarded.
  function automatic logic [15:0] q_of(input logic [15:0] x, input logic [15:0] w);
    longint p;
    longint t;
    logic [15:0] r;
    p = longint'($signed(x)) * longint'($signed(w));
    t = p >>> 13;
    r = {(p < 0), t[14:0]};
    return r;
  endfunction

  task automatic push_exp(input logic [15:0] x, input logic [15:0] w);
    exp_t e;
    acc = acc + q_of(x, w);
    e.d = acc;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_vld(input logic lvl, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge I_CLK);
      if (O_VLD == lvl) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: O_VLD never reached %0d within 40 cycles", name, lvl);
    end
  endtask

  task automatic do_single(input logic [15:0] x, input logic [15:0] w);
    @(negedge I_CLK);
    I_X = x;
    I_W = w;
    I_VLD = 1'b1;
    @(posedge I_CLK);
    #1;
    push_exp(x, w);
    check("fwd_x", int'(O_X), int'(x));
    check("fwd_w", int'(O_W), int'(w));
    @(negedge I_CLK);
    I_VLD = 1'b0;
    wait_vld(1'b1, "pulse_rise");
    wait_vld(1'b0, "pulse_fall");
    @(negedge I_CLK);
  endtask

  // Monitor: compares every O_VLD pulse against the scoreboard head.
  always @(negedge I_CLK) begin
    cyc++;
    if (I_RST_N) begin
      prev_vld = 0;
    end else begin
      if (O_VLD) begin
        check("pulse_width", int'(prev_vld), 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: O_VLD=1 with O_D=0x%0h, expected no pulse", O_D);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("od_at_pulse", int'(O_D), int'(e.d));
          check("latency", cyc - e.cyc, PULSE_LAT);
        end
        if (b2b && have_last) check("b2b_spacing", cyc - last_pulse, PULSE_GAP);
        last_pulse = cyc;
        have_last = 1;
        pulses++;
      end
      prev_vld = O_VLD;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int pb;
    logic [15:0] x;
    logic [15:0] w;

    I_VLD = 1'b0;
    I_X = 16'h0;
    I_W = 16'h0;
    I_RST_N = 1'b0;
    #3 I_RST_N = 1'b1;
    repeat (3) @(negedge I_CLK);
    #1;
    check("rst_vld", int'(O_VLD), 0);
    check("rst_x", int'(O_X), 0);
    check("rst_w", int'(O_W), 0);
    check("rst_d", int'(O_D), 0);
    @(negedge I_CLK);
    I_RST_N = 1'b0;
    repeat (10) @(negedge I_CLK);
    check("idle_no_pulse", pulses, 0);
    check("idle_d", int'(O_D), 0);

    do_single(16'h2000, 16'h2000);
    check("od_one", int'(O_D), 16'h2000);
    check("hold_x", int'(O_X), 16'h2000);
    do_single(16'hE000, 16'h2000);
    check("od_minus_one", int'(O_D), 16'h0000);
    do_single(16'h7FFF, 16'h7FFF);
    check("od_wrap1", int'(O_D), 16'h7FF8);
    do_single(16'h7FFF, 16'h7FFF);
    check("od_wrap2", int'(O_D), 16'hFFF0);

    // Back-to-back with I_VLD held high; operands change on each O_VLD fall.
    b2b = 1;
    have_last = 0;
    @(negedge I_CLK);
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom);
      w = 16'($urandom);
      I_X = x;
      I_W = w;
      I_VLD = 1'b1;
      @(posedge I_CLK);
      #1;
      push_exp(x, w);
      check("b2b_fwd_x", int'(O_X), int'(x));
      check("b2b_fwd_w", int'(O_W), int'(w));
      if (i == 7) begin
        @(negedge I_CLK);
        I_VLD = 1'b0;
      end
      wait_vld(1'b1, "b2b_rise");
      wait_vld(1'b0, "b2b_fall");
    end
    b2b = 0;
    @(negedge I_CLK);
    check("b2b_final_d", int'(O_D), int'(acc));

    // Reset mid-BUSY aborts the operation and clears the accumulator.
    @(negedge I_CLK);
    I_X = 16'h1234;
    I_W = 16'h4321;
    I_VLD = 1'b1;
    @(negedge I_CLK);
    I_VLD = 1'b0;
    repeat (5) @(negedge I_CLK);
    I_RST_N = 1'b1;
    #1;
    check("midrst_vld", int'(O_VLD), 0);
    check("midrst_x", int'(O_X), 0);
    check("midrst_w", int'(O_W), 0);
    check("midrst_d", int'(O_D), 0);
    sb.delete();
    acc = 16'h0000;
    pb = pulses;
    repeat (3) @(negedge I_CLK);
    I_RST_N = 1'b0;
    repeat (25) @(negedge I_CLK);
    check("midrst_no_pulse", pulses, pb);
    do_single(16'h2000, 16'hE000);
    check("after_rst_d", int'(O_D), 16'hE000);

    for (int i = 0; i < 3; i++) begin
      do_single(16'($urandom), 16'($urandom));
    end
    check("final_d", int'(O_D), int'(acc));

    repeat (5) @(negedge I_CLK);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
